// File: rtl/fault_campaign_scheduler.sv
// Fault-injection campaign sequencer: walks the masked gates, pulsing fault, settle/sample
// and logic-reset phases per gate, for a configurable number of passes.
module fault_campaign_scheduler #(
    parameter int unsigned GATE_COUNT    = 4,
    parameter int unsigned FAULT_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic                                              abort,
    input  logic [GATE_COUNT-1:0]                             gate_mask,
    input  logic [7:0]                                        repeat_count,
    output logic [GATE_COUNT-1:0]                             fault_in,
    output logic                                              logic_reset,
    output logic                                              sample,
    output logic [$clog2(GATE_COUNT > 1 ? GATE_COUNT : 2)-1:0] cur_gate,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              aborted
);

    localparam int unsigned GW = $clog2(GATE_COUNT > 1 ? GATE_COUNT : 2);
    localparam logic [7:0] FaultLast  = 8'(FAULT_CYCLES - 1);
    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SettlePre  = 8'(SETTLE_CYCLES - 2);
    localparam logic       SettleOne  = (SETTLE_CYCLES == 1);

    typedef enum logic [2:0] {
        StIdle, StInject, StSettle, StRecover, StDone, StAbort
    } state_e;

    state_e                state_q;
    logic [7:0]            cnt_q;
    logic [7:0]            pass_q;
    logic [7:0]            reps_q;
    logic [GATE_COUNT-1:0] mask_q;

    logic                  has_next;
    logic [GW-1:0]         next_gate;
    logic [7:0]            pass_next;

    function automatic logic [GW-1:0] lowest(input logic [GATE_COUNT-1:0] m);
        logic [GW-1:0] g;
        g = '0;
        for (int i = int'(GATE_COUNT) - 1; i >= 0; i--) begin
            if (m[i]) g = GW'(i);
        end
        return g;
    endfunction

    function automatic logic [GATE_COUNT-1:0] onehot(input logic [GW-1:0] g);
        logic [GATE_COUNT-1:0] v;
        for (int i = 0; i < int'(GATE_COUNT); i++) v[i] = (int'(g) == i);
        return v;
    endfunction

    // Next latched-mask gate strictly above the current one.
    always_comb begin
        has_next  = 1'b0;
        next_gate = cur_gate;
        for (int i = int'(GATE_COUNT) - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(cur_gate))) begin
                has_next  = 1'b1;
                next_gate = GW'(i);
            end
        end
    end

    assign pass_next = pass_q + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pass_q      <= '0;
            reps_q      <= '0;
            mask_q      <= '0;
            fault_in    <= '0;
            logic_reset <= 1'b0;
            sample      <= 1'b0;
            cur_gate    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            sample      <= 1'b0;
            logic_reset <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            if (abort && (state_q == StInject || state_q == StSettle || state_q == StRecover)) begin
                state_q     <= StAbort;
                cnt_q       <= '0;
                fault_in    <= '0;
                logic_reset <= 1'b1;
                aborted     <= 1'b1;
                busy        <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start && (|gate_mask)) begin
                            state_q  <= StInject;
                            mask_q   <= gate_mask;
                            reps_q   <= (repeat_count == 8'd0) ? 8'd1 : repeat_count;
                            pass_q   <= '0;
                            cnt_q    <= '0;
                            cur_gate <= lowest(gate_mask);
                            fault_in <= onehot(lowest(gate_mask));
                            busy     <= 1'b1;
                        end
                    end
                    StInject: begin
                        if (cnt_q == FaultLast) begin
                            state_q  <= StSettle;
                            cnt_q    <= '0;
                            fault_in <= '0;
                            sample   <= SettleOne;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    StSettle: begin
                        if (cnt_q == SettleLast) begin
                            state_q     <= StRecover;
                            cnt_q       <= '0;
                            logic_reset <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_q + 8'd1;
                            sample <= (cnt_q == SettlePre);
                        end
                    end
                    StRecover: begin
                        if (has_next) begin
                            state_q  <= StInject;
                            cur_gate <= next_gate;
                            fault_in <= onehot(next_gate);
                        end else begin
                            pass_q <= pass_next;
                            if (pass_next >= reps_q) begin
                                state_q <= StDone;
                                done    <= 1'b1;
                            end else begin
                                state_q  <= StInject;
                                cur_gate <= lowest(mask_q);
                                fault_in <= onehot(lowest(mask_q));
                            end
                        end
                    end
                    StDone, StAbort: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_q  <= StIdle;
                        busy     <= 1'b0;
                        fault_in <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fault_campaign_scheduler.sv
// Directed bench for fault_campaign_scheduler with GATE_COUNT=4, FAULT_CYCLES=2, SETTLE_CYCLES=4.
module tb_fault_campaign_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] gate_mask;
    logic [7:0] repeat_count;
    logic [3:0] fault_in;
    logic       logic_reset;
    logic       sample;
    logic [1:0] cur_gate;
    logic       busy;
    logic       done;
    logic       aborted;

    int errors = 0;
    int checks = 0;

    logic [8:0] obs;
    assign obs = {fault_in, sample, logic_reset, done, aborted, busy};

    fault_campaign_scheduler #(
        .GATE_COUNT   (4),
        .FAULT_CYCLES (2),
        .SETTLE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .gate_mask   (gate_mask),
        .repeat_count(repeat_count),
        .fault_in    (fault_in),
        .logic_reset (logic_reset),
        .sample      (sample),
        .cur_gate    (cur_gate),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; abort = 1'b0; gate_mask = '0; repeat_count = '0;
        #1;
        checks++;
        if (obs !== 9'b0 || cur_gate !== 2'd0) begin
            errors++;
            $display("FAIL reset_state obs=%b cur_gate=%0d expected obs=0 cur_gate=0", obs, cur_gate);
        end
        tick; tick;
        reset = 1'b0;
        tick;
    endtask

    // mask 0101 repeat 1; optional start/mask/repeat poke mid-campaign.
    task automatic test_two_gates(input bit poke, input string name);
        logic [8:0] exp;
        logic [3:0] fi;
        logic [1:0] cg;
        gate_mask = 4'b0101; repeat_count = 8'd1; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            fi  = (c == 1 || c == 2) ? 4'b0001 : (c == 8 || c == 9) ? 4'b0100 : 4'b0000;
            exp = {fi, (c == 6 || c == 13), (c == 7 || c == 14), (c == 15), 1'b0, (c <= 15)};
            cg  = (c <= 7) ? 2'd0 : 2'd2;
            checks++;
            if (obs !== exp || cur_gate !== cg) begin
                errors++;
                $display("FAIL %s cycle %0d obs=%b cur_gate=%0d expected obs=%b cur_gate=%0d",
                         name, c, obs, cur_gate, exp, cg);
            end
            if (poke && c == 5) begin
                start = 1'b1; gate_mask = 4'b1011; repeat_count = 8'd5;
            end
            if (poke && c == 6) start = 1'b0;
            tick;
        end
    endtask

    task automatic test_single_gate;
        logic [8:0] exp;
        gate_mask = 4'b1000; repeat_count = 8'd0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            exp = {(c <= 2) ? 4'b1000 : 4'b0000, (c == 6), (c == 7), (c == 8), 1'b0, (c <= 8)};
            checks++;
            if (obs !== exp || cur_gate !== 2'd3) begin
                errors++;
                $display("FAIL repeat0 cycle %0d obs=%b cur_gate=%0d expected obs=%b cur_gate=3",
                         c, obs, cur_gate, exp);
            end
            tick;
        end
    endtask

    task automatic test_repeat3;
        logic [8:0] exp;
        int m;
        bit in_run;
        gate_mask = 4'b1000; repeat_count = 8'd3; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            m      = (c - 1) % 7;
            in_run = (c <= 21);
            exp = {(in_run && m < 2) ? 4'b1000 : 4'b0000, (in_run && m == 5),
                   (in_run && m == 6), (c == 22), 1'b0, (c <= 22)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL repeat3 cycle %0d obs=%b expected %b", c, obs, exp);
            end
            tick;
        end
    endtask

    // Follows a mask=1000 campaign, so cur_gate must keep holding 3.
    task automatic test_zero_mask;
        gate_mask = 4'b0000; repeat_count = 8'd2; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick;
            checks++;
            if (obs !== 9'b0 || cur_gate !== 2'd3) begin
                errors++;
                $display("FAIL zero_mask cycle %0d obs=%b cur_gate=%0d expected obs=0 cur_gate=3",
                         c, obs, cur_gate);
            end
        end
        start = 1'b0;
        tick;
    endtask

    task automatic test_abort;
        logic [8:0] exp;
        gate_mask = 4'b1111; repeat_count = 8'd1; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp = {(c <= 2) ? 4'b0001 : 4'b0000, 1'b0, (c == 5), 1'b0, (c == 5), (c <= 5)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort cycle %0d obs=%b expected %b", c, obs, exp);
            end
            abort = (c == 4) || (c == 6);
            tick;
        end
        abort = 1'b0;
    endtask

    task automatic test_async_reset;
        gate_mask = 4'b0101; repeat_count = 8'd1; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (fault_in !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_pre fault_in=%b busy=%b expected 0001 1", fault_in, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (fault_in !== 4'b0000 || busy !== 1'b0 || cur_gate !== 2'd0) begin
            errors++;
            $display("FAIL async_reset fault_in=%b busy=%b cur_gate=%0d expected 0000 0 0",
                     fault_in, busy, cur_gate);
        end
        tick;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++;
            if (obs !== 9'b0) begin
                errors++;
                $display("FAIL async_after cycle %0d obs=%b expected 0", c, obs);
            end
        end
    endtask

    initial begin
        test_reset;
        test_two_gates(1'b0, "two_gates");
        test_single_gate;
        test_repeat3;
        test_zero_mask;
        test_abort;
        test_async_reset;
        test_two_gates(1'b0, "after_reset");
        test_two_gates(1'b1, "back_to_back");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete expected finish");
        $fatal(1, "timeout");
    end

endmodule
